// File: rtl/alu_issue.sv
// Decode/operand-issue stage for the integer ALU: RV32I OP/OP-IMM decode, 32x32 regfile, 2-entry skid output.
// Optional macro ALU_ISSUE_BYPASS_EN: same-cycle writeback data is forwarded into the captured operands.
module alu_issue #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_i_en,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [XLEN-1:0]      out_rs1,
  output logic [XLEN-1:0]      out_rs2,
  output logic [4:0]           out_rd_addr,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic            i_en;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e                 state_q;
  bundle_t                out_q, skid_q, new_b;
  logic                   out_valid_q, in_ready_q, illegal_q;
  logic [ILL_CNT_W-1:0]   ill_cnt_q;
  logic [XLEN-1:0]        rf_q [32];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] ra1, ra2;
  logic       is_op, is_imm, legal;
  logic [XLEN-1:0] rd1, rd2;
  logic       acc, acc_leg, drain;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign ra1    = in_instr[19:15];
  assign ra2    = in_instr[24:20];
  assign is_op  = (opc == OPC_OP);
  assign is_imm = (opc == OPC_IMM);

  always_comb begin
    legal = 1'b0;
    if (is_op)
      legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
    else if (is_imm) begin
      case (f3)
        3'd1:    legal = (f7 == 7'h00);
        3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
        default: legal = 1'b1;
      endcase
    end
  end

  // Operand read at accept time; the captured values never track later writebacks.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : rf_q[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : rf_q[ra2];
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == ra1)) rd1 = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == ra2)) rd2 = wb_data;
`endif
  end

  always_comb begin
    new_b        = '0;
    new_b.i_en   = is_imm;
    new_b.funct3 = f3;
    new_b.funct7 = is_imm ? 7'h00 : f7;
    new_b.rs1    = rd1;
    new_b.rs2    = is_imm ? {{(XLEN-12){in_instr[31]}}, in_instr[31:20]} : rd2;
    new_b.rd     = in_instr[11:7];
  end

  assign acc     = in_valid && in_ready_q;
  assign acc_leg = acc && legal;
  assign drain   = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc_leg) begin
            out_q       <= new_b;
            out_valid_q <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (drain) begin
            // Accept+drain replaces the bundle in place, so there is no bubble.
            if (acc_leg) out_q <= new_b;
            else begin
              out_valid_q <= 1'b0;
              state_q     <= S_EMPTY;
            end
          end else if (acc_leg) begin
            skid_q     <= new_b;
            in_ready_q <= 1'b0;
            state_q    <= S_TWO;
          end
        end
        S_TWO: begin
          if (drain) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= S_ONE;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      illegal_q <= acc && !legal;
      if (acc && !legal && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + 1'b1;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_i_en    = out_q.i_en;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd_addr = out_q.rd;
  assign illegal     = illegal_q;
  assign ill_count   = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue against a queue-based issue model.
module tb_alu_issue;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic        out_i_en;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_rs1, out_rs2;
  logic [4:0]  out_rd_addr;
  logic        illegal;
  logic [7:0]  ill_count;

  alu_issue #(.XLEN(32), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_i_en(out_i_en), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_addr(out_rd_addr),
    .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ien;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [31:0] a;
    bit [31:0] b;
    bit [4:0]  rd;
  } bnd_t;

  bnd_t      mq[$];
  bit [31:0] mrf [32];
  bit        exp_ill;
  int        exp_cnt;
  bit        last_acc;
  int        n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic bit ref_legal(input bit [31:0] w);
    int op = w[6:0], f3 = w[14:12], hi = w[31:25];
    if (op == 'h33) return (hi == 0) || (hi == 32 && (f3 == 0 || f3 == 5));
    if (op == 'h13) begin
      if (f3 == 1) return hi == 0;
      if (f3 == 5) return (hi == 0) || (hi == 32);
      return 1;
    end
    return 0;
  endfunction

  function automatic bit [31:0] rd_reg(input bit [4:0] r, input bit we, input bit [4:0] wa,
                                      input bit [31:0] wd);
    if (r == 0) return 0;
`ifdef ALU_ISSUE_BYPASS_EN
    if (we && wa == r) return wd;
`endif
    return mrf[r];
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    exp_ill = 0;
    exp_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("i_en", out_i_en, mq[0].ien);
      chk("funct3", out_funct3, mq[0].f3);
      chk("funct7", out_funct7, mq[0].f7);
      chk("rs1", out_rs1, mq[0].a);
      chk("rs2", out_rs2, mq[0].b);
      chk("rd", out_rd_addr, mq[0].rd);
    end
    chk("illegal", illegal, exp_ill);
    chk("ill_count", ill_count, exp_cnt);
  endtask

  // Drive one cycle from a negedge, advance the model across the posedge, check at the next negedge.
  task automatic step(input bit v, input bit [31:0] ins, input bit we, input bit [4:0] wa,
                      input bit [31:0] wd, input bit ordy);
    bit   acc, drn, lg;
    bnd_t b;
    in_valid = v; in_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    lg  = ref_legal(ins);
    b.ien = (ins[6:0] == 7'h13);
    b.f3  = ins[14:12];
    b.f7  = b.ien ? 7'd0 : ins[31:25];
    b.a   = rd_reg(ins[19:15], we, wa, wd);
    b.b   = b.ien ? 32'(signed'(ins[31:20])) : rd_reg(ins[24:20], we, wa, wd);
    b.rd  = ins[11:7];
    if (drn) void'(mq.pop_front());
    if (acc && lg) mq.push_back(b);
    exp_ill = acc && !lg;
    if (exp_ill && exp_cnt < 255) exp_cnt++;
    if (we && wa != 0) mrf[wa] = wd;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] w = $urandom;
    int k = $urandom_range(0, 5);
    int s = $urandom_range(0, 3);
    if (k <= 1) begin
      w[6:0] = 7'h33;
      if (s == 0) w[31:25] = 7'h00;
      else if (s == 1) w[31:25] = 7'h20;
    end else if (k <= 3) begin
      w[6:0] = 7'h13;
    end else if (k == 4) begin
      w[6:0] = 7'h13;
      w[14:12] = (s[0]) ? 3'd1 : 3'd5;
      if (s == 0) w[31:25] = 7'h00;
      else if (s == 1) w[31:25] = 7'h20;
    end
    return w;
  endfunction

  localparam bit [31:0] ADD  = 32'h002081B3;
  localparam bit [31:0] SRAI = 32'h4030D213;
  localparam bit [31:0] ECAL = 32'h00000073;

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rs1", out_rs1, 0);
    chk("rst_rs2", out_rs2, 0);
    rst_n = 1'b1;
    check_outputs();

    step(0, 0, 1, 1, 5, 1);
    step(0, 0, 1, 2, 3, 1);
    step(1, ADD, 0, 0, 0, 1);
    chk("add_valid", out_valid, 1);
    chk("add_rs1", out_rs1, 5);
    chk("add_rs2", out_rs2, 3);
    chk("add_rd", out_rd_addr, 3);
    step(1, SRAI, 0, 0, 0, 1);
    chk("srai_ien", out_i_en, 1);
    chk("srai_f3", out_funct3, 5);
    chk("srai_rs2", out_rs2, 32'h403);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: two accepts fill output+skid, third waits at the input.
    step(1, ADD, 0, 0, 0, 0);
    step(1, SRAI, 0, 0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    step(1, 32'h00208233, 0, 0, 0, 0);
    chk("bp_hold_rs2", out_rs2, 3);
    n = 0;
    do begin
      step(1, 32'h00208233, 0, 0, 0, 1);
      n++;
    end while (!last_acc && n < 8);
    chk("bp_accept_timeout", last_acc, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);

    step(1, ECAL, 0, 0, 0, 1);
    chk("ecall_ill", illegal, 1);
    chk("ecall_cnt", ill_count, 1);
    chk("ecall_noissue", out_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ecall_pulse", illegal, 0);
    repeat (300) step(1, ECAL, 0, 0, 0, 1);
    chk("ill_sat", ill_count, 255);

    step(1, ADD, 1, 1, 32'hDEAD, 1);
`ifdef ALU_ISSUE_BYPASS_EN
    chk("same_cyc_rs1", out_rs1, 32'hDEAD);
`else
    chk("same_cyc_rs1", out_rs1, 5);
`endif
    step(1, ADD, 0, 0, 0, 1);
    chk("after_wb_rs1", out_rs1, 32'hDEAD);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 1), 5'($urandom),
           $urandom, $urandom_range(0, 2) != 0);
    n = 0;
    while (mq.size() > 0 && n < 8) begin
      step(0, 0, 0, 0, 0, 1);
      n++;
    end
    chk("drain_timeout", mq.size(), 0);

    // Asynchronous reset while both entries are held.
    step(0, 0, 1, 1, 32'h1234, 1);
    step(1, ADD, 0, 0, 0, 0);
    step(1, SRAI, 0, 0, 0, 0);
    chk("two_in_ready", in_ready, 0);
    in_valid = 0; wb_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_cnt", ill_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    step(0, 0, 0, 0, 0, 1);
    step(1, ADD, 0, 0, 0, 1);
    chk("arst_x1", out_rs1, 0);
    chk("arst_valid", out_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/operand-issue stage that feeds the integer ALU.
- Accepts 32-bit RV32I instructions on a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011).
- Reads operands from an internal 32x32 register file, which is written by the writeback port.
- Presents i_en/funct3/funct7/rs1/rs2 plus the destination address to the ALU on a registered valid/ready output with a 2-entry skid buffer.

Parameters:
XLEN, 32, operand/register width (only 32 supported)
ILL_CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  stage can accept instruction
in_instr  input  32  raw instruction word
wb_en  input  1  register-file write enable
wb_addr  input  5  write address
wb_data  input  32  write data
out_valid  output  1  issue bundle valid
out_ready  input  1  ALU/downstream accepts bundle
out_i_en  output  1  1 = immediate form (OP-IMM), 0 = register form
out_funct3  output  3  instr[14:12]
out_funct7  output  7  instr[31:25] for OP; 0 for OP-IMM
out_rs1  output  32  rs1 register value
out_rs2  output  32  rs2 value (OP) or sign-extended imm[11:0] (OP-IMM)
out_rd_addr  output  5  instr[11:7]
illegal  output  1  one-cycle pulse on dropped illegal instruction
ill_count  output  ILL_CNT_W  saturating illegal count

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, illegal=0, ill_count=0, skid empty, in_ready=1.
  - out_* data fields = 0.
  - Register file cleared to 0.
- Handshake:
  - A transfer occurs on a clock edge with valid&&ready.
  - in_ready = !skid_full; it is registered and has no combinational path from out_ready.
  - out_valid/out_* hold stable while out_valid && !out_ready.
- Latency:
  - Accepted legal instruction appears on out_* the next cycle if the output register is empty or draining.
  - Otherwise it is stored in the skid entry and issued after the current bundle transfers.
  - Strict in-order; no drops except illegal instructions.
- Skid states: EMPTY, ONE (output reg full), TWO (output + skid full, in_ready=0).
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept+drain or on neither.
  - ONE -> TWO on accept without drain.
  - ONE -> EMPTY on drain without accept.
  - TWO -> ONE on drain; the skid entry moves to the output register.
- Operand capture:
  - Register-file read happens at accept; values are frozen in the bundle.
  - Later writebacks do not update held bundles. Hazard scoreboarding is upstream's responsibility.
- x0: reads return 0; writes with wb_addr=0 are ignored.
- Register file write occurs on the clock edge when wb_en=1.
- Immediate: out_rs2 = {{20{instr[31]}}, instr[31:20]}.
  - Shifts: imm[11:5] is kept in out_rs2 so the ALU can distinguish SRLI/SRAI.
- Legal set:
  - OP with funct7=0x00 (any funct3), or funct7=0x20 with funct3 in {0,5}.
  - OP-IMM with any funct3, except: funct3=1 requires imm[11:5]=0; funct3=5 requires imm[11:5] in {0x00,0x20}.
- Illegal instruction (other opcode or violating the rules above):
  - Accepted (in_ready honoured) but not issued.
  - illegal pulses high for exactly the cycle after accept.
  - ill_count increments and saturates at all-ones.
- Simultaneous accept+drain in ONE: new bundle replaces the old one in the same edge; no bubble.
- Reset mid-operation: all held bundles discarded; no out_valid after reset deasserts until a new accept.

Optional Feature:
- Macro ALU_ISSUE_BYPASS_EN.
- Defined: when wb_en && wb_addr!=0 && wb_addr matches rs1/rs2 of the instruction accepted in the same cycle, the captured operand is wb_data (write-before-read).
- Undefined: same-cycle capture returns the pre-write register value; the write is still performed.

Test Plan:
- Reset, then write x1=5 and x2=3 via wb; then issue ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, i_en=0, funct3=0, funct7=0, rs1=5, rs2=3, rd_addr=3.
- SRAI x4,x1,3 (0x4030D213) -> i_en=1, funct3=5, funct7=0, out_rs2=0x00000403.
- Hold out_ready=0 and send 3 instructions back-to-back -> in_ready drops after the second accept; third is held at input. Raise out_ready -> bundles emerge in order with no loss or duplication.
- Opcode 0x00000073 (ECALL) -> no out_valid, illegal=1 for one cycle, ill_count=1. Send 300 illegal instructions -> ill_count saturates at 255.
- Same cycle: wb x1=0xDEAD and accept ADD reading x1:
  - ALU_ISSUE_BYPASS_EN defined -> rs1=0xDEAD.
  - Undefined -> rs1 = old x1 value.
- Assert rst_n low while in TWO state -> out_valid=0 and in_ready=1 immediately (asynchronously); x1 reads 0 on the next accept.
